// File: rtl/tl_ctrl.sv
// Traffic-light control FSM: sequences INIT->G->Y->R phases from datapath timeout flags,
// with hold, pedestrian shortening of G, fault trapping into SAFE and a round counter.
module tl_ctrl #(
  parameter int STATE_W = 4,
  parameter int S_INIT  = 0,
  parameter int S_R     = 1,
  parameter int S_G     = 2,
  parameter int S_Y     = 3,
  parameter int BLANK   = 2,
  parameter int CYC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               hold,
  input  logic               ped_req,
  input  logic               clr_fault,
  input  logic [STATE_W-1:0] int_flags,
  output logic [STATE_W-1:0] state,
  output logic               cnt_rst,
  output logic               phase_done,
  output logic               ped_ack,
  output logic               fault,
  output logic [CYC_W-1:0]   cycle_cnt
);

  localparam int BW = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
  localparam logic [BW-1:0] BLANK_V = BW'(BLANK);

  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_G, ST_Y, ST_R, ST_SAFE} fsm_e;

  fsm_e               cur_q, cur_d;
  logic [BW-1:0]      blank_q, blank_d;
  logic               ped_q, ped_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               cnt_rst_q, cnt_rst_d;
  logic               phase_done_q, phase_done_d;
  logic               ped_ack_q, ped_ack_d;
  logic               fault_q, fault_d;
  logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;

  logic               running, blanked, timeout, stray, entering;
  logic [STATE_W-1:0] cur_vec;

  // SAFE shows the red lamp only, so it shares the S_R bit.
  function automatic logic [STATE_W-1:0] phase_vec(input fsm_e s);
    logic [STATE_W-1:0] v;
    v = '0;
    case (s)
      ST_INIT: v[S_INIT] = 1'b1;
      ST_G:    v[S_G]    = 1'b1;
      ST_Y:    v[S_Y]    = 1'b1;
      ST_R:    v[S_R]    = 1'b1;
      ST_SAFE: v[S_R]    = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic fsm_e next_phase(input fsm_e s);
    case (s)
      ST_INIT: return ST_G;
      ST_G:    return ST_Y;
      ST_Y:    return ST_R;
      ST_R:    return ST_INIT;
      default: return ST_IDLE;
    endcase
  endfunction

  always_comb begin
    cur_d        = cur_q;
    blank_d      = blank_q;
    ped_d        = ped_q;
    ped_ack_d    = 1'b0;
    fault_d      = fault_q;
    cycle_cnt_d  = cycle_cnt_q;

    running = (cur_q == ST_INIT) || (cur_q == ST_G) || (cur_q == ST_Y) || (cur_q == ST_R);
    blanked = (blank_q != '0);
    cur_vec = phase_vec(cur_q);
    timeout = |(int_flags & cur_vec);
    stray   = |(int_flags & ~cur_vec);

    if (running && ped_req) ped_d = 1'b1;

    case (cur_q)
      ST_IDLE: begin
        if (en) cur_d = ST_INIT;
      end
      ST_SAFE: begin
        if (clr_fault) begin
          cur_d   = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      default: begin
        if (!blanked && !hold && stray) begin
          cur_d   = ST_SAFE;
          fault_d = 1'b1;
        end else if (hold) begin
          blank_d = BLANK_V;
        end else if (blanked) begin
          blank_d = blank_q - BW'(1);
        end else if (cur_q == ST_G && ped_q) begin
          cur_d     = ST_Y;
          ped_d     = 1'b0;
          ped_ack_d = 1'b1;
        end else if (timeout) begin
          cur_d = next_phase(cur_q);
          if (cur_q == ST_R) cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        end
      end
    endcase

    // Every entry into a lit phase restarts blanking and the datapath counter.
    entering = (cur_d != cur_q) &&
               ((cur_d == ST_INIT) || (cur_d == ST_G) || (cur_d == ST_Y) || (cur_d == ST_R));
    if (entering) blank_d = BLANK_V;
    phase_done_d = entering;
    cnt_rst_d    = (cur_d == ST_IDLE) || (cur_d == ST_SAFE) || entering || (hold && running);
    state_d      = phase_vec(cur_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q        <= ST_IDLE;
      blank_q      <= '0;
      ped_q        <= 1'b0;
      state_q      <= '0;
      cnt_rst_q    <= 1'b1;
      phase_done_q <= 1'b0;
      ped_ack_q    <= 1'b0;
      fault_q      <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      cur_q        <= cur_d;
      blank_q      <= blank_d;
      ped_q        <= ped_d;
      state_q      <= state_d;
      cnt_rst_q    <= cnt_rst_d;
      phase_done_q <= phase_done_d;
      ped_ack_q    <= ped_ack_d;
      fault_q      <= fault_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign state      = state_q;
  assign cnt_rst    = cnt_rst_q;
  assign phase_done = phase_done_q;
  assign ped_ack    = ped_ack_q;
  assign fault      = fault_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_tl_ctrl.sv
// Directed self-checking bench for tl_ctrl; a 2-bit round counter makes wrap reachable quickly.
module tb_tl_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       hold;
  logic       ped_req;
  logic       clr_fault;
  logic [3:0] int_flags;
  logic [3:0] state;
  logic       cnt_rst;
  logic       phase_done;
  logic       ped_ack;
  logic       fault;
  logic [1:0] cycle_cnt;

  int total;
  int bad;

  tl_ctrl #(.STATE_W(4), .S_INIT(0), .S_R(1), .S_G(2), .S_Y(3), .BLANK(2), .CYC_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .hold(hold), .ped_req(ped_req),
    .clr_fault(clr_fault), .int_flags(int_flags), .state(state), .cnt_rst(cnt_rst),
    .phase_done(phase_done), .ped_ack(ped_ack), .fault(fault), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one phase flag from a phase's first cycle until the next phase is entered.
  task automatic step_phase(input logic [3:0] f);
    int_flags = f;
    tick();
    tick();
    tick();
    int_flags = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (state !== 4'b0000 || cnt_rst !== 1'b1 || phase_done !== 1'b0 || ped_ack !== 1'b0 ||
        fault !== 1'b0 || cycle_cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset: state=%b cnt_rst=%b pd=%b ack=%b fault=%b cyc=%0d need 0000 1 0 0 0 0",
               state, cnt_rst, phase_done, ped_ack, fault, cycle_cnt);
    end
    tick();
    total++;
    if (state !== 4'b0000 || cnt_rst !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_hold: state=%b cnt_rst=%b need 0000 1", state, cnt_rst);
    end
  endtask

  task automatic test_start();
    en = 1'b1;
    tick();
    en = 1'b0;
    total++;
    if (state !== 4'b0001 || cnt_rst !== 1'b1 || phase_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_entry: state=%b cnt_rst=%b pd=%b need 0001 1 1", state, cnt_rst, phase_done);
    end
    tick();
    total++;
    if (state !== 4'b0001 || cnt_rst !== 1'b0 || phase_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_second: state=%b cnt_rst=%b pd=%b need 0001 0 0", state, cnt_rst, phase_done);
    end
  endtask

  task automatic test_cycle();
    logic [3:0] flags [4];
    logic [3:0] nxt [4];
    int pulses;
    flags = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
    nxt   = '{4'b0100, 4'b1000, 4'b0010, 4'b0001};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      int_flags = flags[i];
      if (i > 0) tick();
      tick();
      total++;
      if (state !== flags[i] || phase_done !== 1'b0 || cycle_cnt !== 2'd0) begin
        bad++;
        $display("[TB] FAIL cycle_hold%0d: state=%b pd=%b cyc=%0d need %b 0 0", i, state, phase_done, cycle_cnt, flags[i]);
      end
      tick();
      int_flags = 4'b0000;
      if (phase_done === 1'b1) pulses++;
      total++;
      if (state !== nxt[i] || cnt_rst !== 1'b1) begin
        bad++;
        $display("[TB] FAIL cycle_step%0d: state=%b cnt_rst=%b need %b 1", i, state, cnt_rst, nxt[i]);
      end
    end
    total++;
    if (pulses !== 4 || cycle_cnt !== 2'd1) begin
      bad++;
      $display("[TB] FAIL cycle_count: pulses=%0d cyc=%0d need 4 1", pulses, cycle_cnt);
    end
  endtask

  task automatic test_stale_flag();
    int_flags = 4'b0001;
    tick();
    tick();
    tick();
    total++;
    if (state !== 4'b0100 || fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stale_c0: state=%b fault=%b need 0100 0", state, fault);
    end
    tick();
    total++;
    if (state !== 4'b0100 || fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stale_c1: state=%b fault=%b need 0100 0", state, fault);
    end
    int_flags = 4'b0100;
    tick();
    total++;
    if (state !== 4'b0100 || fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stale_c2: state=%b fault=%b need 0100 0", state, fault);
    end
    tick();
    int_flags = 4'b0000;
    total++;
    if (state !== 4'b1000 || fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stale_adv: state=%b fault=%b need 1000 0", state, fault);
    end
  endtask

  task automatic test_ped();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    total++;
    if (ped_ack !== 1'b0 || state !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL ped_in_y: state=%b ack=%b need 1000 0", state, ped_ack);
    end
    int_flags = 4'b1000;
    tick();
    tick();
    int_flags = 4'b0000;
    step_phase(4'b0010);
    step_phase(4'b0001);
    total++;
    if (state !== 4'b0100 || cycle_cnt !== 2'd2 || ped_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ped_reach_g: state=%b cyc=%0d ack=%b need 0100 2 0", state, cycle_cnt, ped_ack);
    end
    tick();
    tick();
    total++;
    if (state !== 4'b0100 || ped_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ped_blank: state=%b ack=%b need 0100 0", state, ped_ack);
    end
    tick();
    total++;
    if (state !== 4'b1000 || ped_ack !== 1'b1 || phase_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ped_advance: state=%b ack=%b pd=%b need 1000 1 1", state, ped_ack, phase_done);
    end
    tick();
    total++;
    if (ped_ack !== 1'b0 || state !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL ped_pulse: state=%b ack=%b need 1000 0", state, ped_ack);
    end
  endtask

  task automatic test_hold();
    int nbad;
    int_flags = 4'b1000;
    tick();
    tick();
    int_flags = 4'b0010;
    hold = 1'b1;
    nbad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (state !== 4'b0010 || cnt_rst !== 1'b1) nbad++;
    end
    hold = 1'b0;
    total++;
    if (nbad !== 0) begin
      bad++;
      $display("[TB] FAIL hold_freeze: bad_cycles=%0d need 0", nbad);
    end
    tick();
    total++;
    if (state !== 4'b0010 || cnt_rst !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_rel1: state=%b cnt_rst=%b need 0010 0", state, cnt_rst);
    end
    tick();
    total++;
    if (state !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL hold_rel2: state=%b need 0010", state);
    end
    tick();
    int_flags = 4'b0000;
    total++;
    if (state !== 4'b0001 || cycle_cnt !== 2'd3) begin
      bad++;
      $display("[TB] FAIL hold_adv: state=%b cyc=%0d need 0001 3", state, cycle_cnt);
    end
  endtask

  task automatic test_fault_wrap();
    step_phase(4'b0001);
    step_phase(4'b0100);
    tick();
    tick();
    int_flags = 4'b0101;
    tick();
    int_flags = 4'b0000;
    total++;
    if (state !== 4'b0010 || fault !== 1'b1 || cnt_rst !== 1'b1 || phase_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fault_trip: state=%b fault=%b cnt_rst=%b pd=%b need 0010 1 1 0",
               state, fault, cnt_rst, phase_done);
    end
    en = 1'b1;
    int_flags = 4'b0010;
    tick();
    en = 1'b0;
    int_flags = 4'b0000;
    total++;
    if (state !== 4'b0010 || fault !== 1'b1 || cnt_rst !== 1'b1) begin
      bad++;
      $display("[TB] FAIL safe_stay: state=%b fault=%b cnt_rst=%b need 0010 1 1", state, fault, cnt_rst);
    end
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    total++;
    if (state !== 4'b0000 || fault !== 1'b0 || cnt_rst !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fault_clear: state=%b fault=%b cnt_rst=%b need 0000 0 1", state, fault, cnt_rst);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    step_phase(4'b0001);
    step_phase(4'b0100);
    step_phase(4'b1000);
    step_phase(4'b0010);
    total++;
    if (state !== 4'b0001 || cycle_cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL cyc_wrap: state=%b cyc=%0d need 0001 0", state, cycle_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int_flags = 4'b0001;
    en = 1'b1;
    reset = 1'b1;
    tick();
    total++;
    if (state !== 4'b0000 || cnt_rst !== 1'b1 || phase_done !== 1'b0 || fault !== 1'b0 ||
        cycle_cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid: state=%b cnt_rst=%b pd=%b fault=%b cyc=%0d need 0000 1 0 0 0",
               state, cnt_rst, phase_done, fault, cycle_cnt);
    end
    reset = 1'b0;
    en = 1'b0;
    int_flags = 4'b0000;
    tick();
    total++;
    if (state !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_idle: state=%b need 0000", state);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    en = 1'b0;
    hold = 1'b0;
    ped_req = 1'b0;
    clr_fault = 1'b0;
    int_flags = 4'b0000;
    test_reset();
    test_start();
    test_cycle();
    test_stale_flag();
    test_ped();
    test_hold();
    test_fault_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
